// File: rtl/inst_mem_loader.sv
// Boot-time instruction memory: assembles a length-prefixed byte stream into
// 32-bit big-endian words, holds the core in reset until the image is loaded,
// then serves combinational instruction fetches.
//
// Ports:
//   clk, rst        - clock, asynchronous active-high reset
//   in_valid/in_data/in_ready - byte load stream (handshake on in_valid & in_ready)
//   cpu_rst         - registered core reset, high until the image is loaded
//   rom_ce/rom_addr - fetch enable and byte address from the core
//   rom_data        - fetched word (0 when disabled, out of range or unloaded)
//   loaded_words    - min(words received, DEPTH)
//   overflow        - header declared more than DEPTH words
module inst_mem_loader #(
    parameter int unsigned ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              cpu_rst,
    input  logic              rom_ce,
    input  logic [31:0]       rom_addr,
    output logic [31:0]       rom_data,
    output logic [ADDR_W:0]   loaded_words,
    output logic              overflow
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;
    localparam int unsigned LW_W  = ADDR_W + 1;
    localparam int unsigned CNT_W = 16;

    typedef enum logic [1:0] {
        S_LEN_HI = 2'd0,
        S_LEN_LO = 2'd1,
        S_LOAD   = 2'd2,
        S_RUN    = 2'd3
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [15:0]        len;
    logic [1:0]         byte_cnt;
    logic [CNT_W-1:0]   word_cnt;
    logic [23:0]        shreg;
    logic               ram_we;

    logic [31:0]        mem [DEPTH];

    logic               accept;
    logic               last_byte;
    logic               last_word;
    logic               word_in_range;
    logic               len_zero;

    // Handshake is derived straight from state so nothing loops through in_ready.
    assign accept        = in_valid & (state != S_RUN) & ~rst;
    assign last_byte     = (byte_cnt == 2'd3);
    assign last_word     = ((17'(word_cnt) + 17'd1) == 17'(len));
    assign word_in_range = (17'(word_cnt) < 17'(DEPTH));
    assign len_zero      = ({len[15:8], in_data} == 16'd0);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_LEN_HI;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_LEN_HI: if (accept) state_nxt = S_LEN_LO;
            S_LEN_LO: if (accept) state_nxt = len_zero ? S_RUN : S_LOAD;
            S_LOAD:   if (accept && last_byte && last_word) state_nxt = S_RUN;
            S_RUN:    state_nxt = S_RUN;
            default:  state_nxt = S_LEN_HI;
        endcase
    end

    // Output / control decode
    always_comb begin
        in_ready = 1'b0;
        ram_we   = 1'b0;
        if (!rst && state != S_RUN) begin
            in_ready = 1'b1;
        end
        if (accept && state == S_LOAD && last_byte && word_in_range) begin
            ram_we = 1'b1;
        end
    end

    // Header capture, word assembly and counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            len      <= 16'd0;
            byte_cnt <= 2'd0;
            word_cnt <= '0;
            shreg    <= 24'd0;
            overflow <= 1'b0;
            cpu_rst  <= 1'b1;
        end else begin
            // Falls on exactly the edge that enters RUN.
            cpu_rst <= (state_nxt != S_RUN);
            if (accept) begin
                if (state == S_LEN_HI) begin
                    len[15:8] <= in_data;
                end else if (state == S_LEN_LO) begin
                    len[7:0]  <= in_data;
                    overflow  <= (17'({len[15:8], in_data}) > 17'(DEPTH));
                end else if (state == S_LOAD) begin
                    byte_cnt <= byte_cnt + 2'd1;
                    if (last_byte) begin
                        word_cnt <= word_cnt + CNT_W'(1);
                    end else begin
                        shreg <= {shreg[15:0], in_data};
                    end
                end
            end
        end
    end

    // Instruction RAM; contents survive reset and are masked by loaded_words.
    always_ff @(posedge clk) begin
        if (ram_we) begin
            mem[word_cnt[ADDR_W-1:0]] <= {shreg, in_data};
        end
    end

    assign loaded_words = (17'(word_cnt) >= 17'(DEPTH)) ? LW_W'(DEPTH) : LW_W'(word_cnt);

    // Combinational fetch
    logic [ADDR_W-1:0] fetch_idx;
    logic              fetch_hit;
    logic              addr_lsb_unused;

    assign fetch_idx       = rom_addr[ADDR_W+1:2];
    assign addr_lsb_unused = ^rom_addr[1:0];
    assign fetch_hit       = rom_ce
                           && (rom_addr[31:ADDR_W+2] == '0)
                           && ({1'b0, fetch_idx} < loaded_words);
    assign rom_data        = fetch_hit ? mem[fetch_idx] : 32'd0;

endmodule

// File: tb/tb_inst_mem_loader.sv
module tb_inst_mem_loader;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        sweep;
    logic        dir_ce;
    logic [31:0] dir_addr;
    logic        sw_ce;
    logic [31:0] sw_addr;
    logic        rom_ce;
    logic [31:0] rom_addr;
    logic        chk_en;

    logic        rdy_b, crst_b, ovf_b;
    logic [31:0] data_b;
    logic [10:0] lw_b;
    logic        rdy_s, crst_s, ovf_s;
    logic [31:0] data_s;
    logic [2:0]  lw_s;

    int n_chk;
    int n_fail;
    int cyc;

    assign rom_ce   = sweep ? sw_ce   : dir_ce;
    assign rom_addr = sweep ? sw_addr : dir_addr;

    inst_mem_loader #(.ADDR_W(10)) dut_big (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .in_ready(rdy_b), .cpu_rst(crst_b), .rom_ce(rom_ce), .rom_addr(rom_addr),
        .rom_data(data_b), .loaded_words(lw_b), .overflow(ovf_b)
    );

    inst_mem_loader #(.ADDR_W(2)) dut_small (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .in_ready(rdy_s), .cpu_rst(crst_s), .rom_ce(rom_ce), .rom_addr(rom_addr),
        .rom_data(data_s), .loaded_words(lw_s), .overflow(ovf_s)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: the image is simply the list of accepted bytes since reset.
    logic [7:0] img[$];

    function automatic int m_len();
        if (img.size() < 2) return 0;
        return int'({img[0], img[1]});
    endfunction

    function automatic bit m_running();
        return (img.size() >= 2) && (img.size() >= 2 + 4 * m_len());
    endfunction

    function automatic int m_loaded(input int depth);
        int w;
        w = (img.size() < 2) ? 0 : (img.size() - 2) / 4;
        return (w > depth) ? depth : w;
    endfunction

    function automatic bit m_ovf(input int depth);
        return (img.size() >= 2) && (m_len() > depth);
    endfunction

    function automatic logic [31:0] m_rom(input int depth, input logic ce, input logic [31:0] addr);
        longint idx;
        int b;
        idx = longint'(addr >> 2);
        if (!ce) return 32'd0;
        if (idx >= longint'(depth)) return 32'd0;
        if (idx >= longint'(m_loaded(depth))) return 32'd0;
        b = 2 + 4 * int'(idx);
        return {img[b], img[b+1], img[b+2], img[b+3]};
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) img.delete();
        else if (in_valid && !m_running()) img.push_back(in_data);
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at t=%0t", name, got, exp, $time);
        end
    endtask

    // Per-cycle comparison of both DUTs against the model
    always @(negedge clk) begin
        if (chk_en) begin
            chk("big.in_ready",     32'(rdy_b),  32'(!rst && !m_running()));
            chk("big.cpu_rst",      32'(crst_b), 32'(!m_running()));
            chk("big.loaded_words", 32'(lw_b),   32'(m_loaded(1024)));
            chk("big.overflow",     32'(ovf_b),  32'(m_ovf(1024)));
            chk("big.rom_data",     data_b,      m_rom(1024, rom_ce, rom_addr));
            chk("small.in_ready",     32'(rdy_s),  32'(!rst && !m_running()));
            chk("small.cpu_rst",      32'(crst_s), 32'(!m_running()));
            chk("small.loaded_words", 32'(lw_s),   32'(m_loaded(4)));
            chk("small.overflow",     32'(ovf_s),  32'(m_ovf(4)));
            chk("small.rom_data",     data_s,      m_rom(4, rom_ce, rom_addr));
        end
    end

    // Background fetch sweep over in-range, out-of-range and disabled fetches
    logic [31:0] sweep_tab [8];
    initial begin
        sweep_tab[0] = 32'h0000_0000; sweep_tab[1] = 32'h0000_0005;
        sweep_tab[2] = 32'h0000_0008; sweep_tab[3] = 32'h0000_000E;
        sweep_tab[4] = 32'h0000_0010; sweep_tab[5] = 32'h0000_0013;
        sweep_tab[6] = 32'h0000_1000; sweep_tab[7] = 32'hFFFF_FFFC;
        sw_ce = 1'b0;
        sw_addr = 32'd0;
        forever begin
            for (int i = 0; i < 40; i++) begin
                @(posedge clk);
                #1;
                sw_addr = sweep_tab[i % 8];
                sw_ce   = ((i % 5) != 4);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        step();
    endtask

    // Presents one byte and holds it until the handshake completes (bounded).
    task automatic send_byte(input logic [7:0] b);
        logic rdy;
        bit   done;
        done = 1'b0;
        in_valid = 1'b1;
        in_data  = b;
        for (int t = 0; t < 8 && !done; t++) begin
            @(negedge clk);
            rdy = rdy_b;
            @(posedge clk);
            #2;
            if (rdy) done = 1'b1;
        end
        chk("send_byte.accepted", 32'(done), 32'd1);
    endtask

    task automatic send_img(input logic [7:0] bytes[$], input bit gaps);
        for (int i = 0; i < bytes.size(); i++) begin
            send_byte(bytes[i]);
            if (gaps) begin
                in_valid = 1'b0;
                in_data  = 8'hXX;
                step();
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic fetch_chk(input string name, input logic ce, input logic [31:0] addr,
                             input logic [31:0] exp_big, input logic [31:0] exp_small);
        sweep    = 1'b0;
        dir_ce   = ce;
        dir_addr = addr;
        #1;
        chk({name, ".big"},   data_b, exp_big);
        chk({name, ".small"}, data_s, exp_small);
    endtask

    logic [7:0] img1[$];
    logic [7:0] img4[$];
    logic [7:0] bytes[$];
    int t0;

    initial begin
        n_chk = 0; n_fail = 0; cyc = 0;
        chk_en = 1'b0;
        rst = 1'b1;
        in_valid = 1'b0;
        in_data = 8'h00;
        sweep = 1'b1;
        dir_ce = 1'b0;
        dir_addr = 32'd0;
        step();
        chk_en = 1'b1;
        step();
        chk("reset.cpu_rst", 32'(crst_b), 32'd1);
        chk("reset.in_ready", 32'(rdy_b), 32'd0);
        rst = 1'b0;
        step();

        // Back-to-back two-word image
        img1 = '{8'h00, 8'h02, 8'h34, 8'h01, 8'h00, 8'h05, 8'h34, 8'h02, 8'h00, 8'h07};
        t0 = cyc;
        send_img(img1, 1'b0);
        chk("b2b.accept_cycles", 32'(cyc - t0), 32'd10);
        chk("b2b.cpu_rst", 32'(crst_b), 32'd0);
        chk("b2b.loaded", 32'(lw_b), 32'd2);
        fetch_chk("b2b.fetch0", 1'b1, 32'h0, 32'h3401_0005, 32'h3401_0005);
        fetch_chk("b2b.fetch4", 1'b1, 32'h4, 32'h3402_0007, 32'h3402_0007);
        fetch_chk("b2b.fetch8", 1'b1, 32'h8, 32'h0, 32'h0);
        sweep = 1'b1;
        repeat (8) step();

        // Same image with in_valid toggling
        do_reset();
        send_img(img1, 1'b1);
        chk("gap.cpu_rst", 32'(crst_b), 32'd0);
        chk("gap.loaded", 32'(lw_s), 32'd2);
        fetch_chk("gap.fetch7", 1'b1, 32'h7, 32'h3402_0007, 32'h3402_0007);
        sweep = 1'b1;
        repeat (8) step();

        // Empty image, then stream ignored in RUN
        do_reset();
        bytes = '{8'h00, 8'h00};
        send_img(bytes, 1'b0);
        chk("zero.cpu_rst", 32'(crst_b), 32'd0);
        chk("zero.in_ready", 32'(rdy_b), 32'd0);
        chk("zero.loaded", 32'(lw_b), 32'd0);
        fetch_chk("zero.fetch0", 1'b1, 32'h0, 32'h0, 32'h0);
        sweep = 1'b1;
        in_valid = 1'b1;
        in_data = 8'h55;
        repeat (4) step();
        in_valid = 1'b0;
        chk("zero.loaded_after_ignored", 32'(lw_b), 32'd0);
        repeat (4) step();

        // Five-word image: overflows the 4-word instance only
        do_reset();
        img4 = '{8'h00, 8'h05};
        for (int k = 0; k < 5; k++) begin
            img4.push_back(8'hA0 + 8'(k));
            img4.push_back(8'h01);
            img4.push_back(8'h02);
            img4.push_back(8'h03 + 8'(k));
        end
        t0 = cyc;
        send_img(img4, 1'b0);
        chk("ovf.accept_cycles", 32'(cyc - t0), 32'd22);
        chk("ovf.small.overflow", 32'(ovf_s), 32'd1);
        chk("ovf.big.overflow", 32'(ovf_b), 32'd0);
        chk("ovf.small.loaded", 32'(lw_s), 32'd4);
        chk("ovf.big.loaded", 32'(lw_b), 32'd5);
        chk("ovf.small.cpu_rst", 32'(crst_s), 32'd0);
        fetch_chk("ovf.fetchC", 1'b1, 32'hC, 32'hA301_0206, 32'hA301_0206);
        fetch_chk("ovf.fetch10", 1'b1, 32'h10, 32'hA401_0207, 32'h0);
        sweep = 1'b1;
        repeat (8) step();

        // Reset in the middle of a load, then a fresh one-word image
        do_reset();
        bytes = '{8'h00, 8'h03, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
        send_img(bytes, 1'b0);
        chk("mid.cpu_rst_before", 32'(crst_b), 32'd1);
        chk("mid.loaded_before", 32'(lw_b), 32'd1);
        do_reset();
        chk("mid.loaded_cleared", 32'(lw_b), 32'd0);
        chk("mid.cpu_rst_cleared", 32'(crst_b), 32'd1);
        bytes = '{8'h00, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
        send_img(bytes, 1'b0);
        chk("mid.cpu_rst", 32'(crst_b), 32'd0);
        chk("mid.loaded", 32'(lw_b), 32'd1);
        fetch_chk("mid.fetch0", 1'b1, 32'h0, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
        fetch_chk("mid.fetch4", 1'b1, 32'h4, 32'h0, 32'h0);
        fetch_chk("mid.ce_off", 1'b0, 32'h0, 32'h0, 32'h0);
        sweep = 1'b1;
        repeat (8) step();

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
